avalon_mm_mem_slave: RTL and testbench
======================================

// Module: avalon_mm_mem_slave
// PURPOSE
//  Burst-capable Avalon-MM slave memory model; consumes transactions driven on the avalon_mm_if
//  master side (kernel/bench driver) and answers with waitrequest/readdata/readdatavalid.
//  Stands in for the board global memory in kernel_sim. Fixed read latency, optional periodic
//  waitrequest stalls for back-pressure coverage, sticky protocol-error flag.
// PARAMETERS
//  ADDR_WIDTH         32            byte address width
//  DATA_WIDTH         64            data bus width; power of 2, >=8
//  BURST_COUNT_WIDTH  8             burstcount width
//  BYTE_ENABLE_WIDTH  DATA_WIDTH/8  byteenable width
//  MEM_WORDS_LOG2     10            memory depth = 2**MEM_WORDS_LOG2 words of DATA_WIDTH
//  READ_LATENCY       2             cycles from word issue to readdatavalid; >=1
//  WAIT_PERIOD        0             0: no stall; N>=2: waitrequest forced high 1 cycle in every N
// PORTS
//  clk            in   1                  clock
//  rst_n          in   1                  asynchronous active-low reset
//  address        in   ADDR_WIDTH         byte address of first beat
//  burstcount     in   BURST_COUNT_WIDTH  beats in burst
//  writedata      in   DATA_WIDTH         write beat data
//  byteenable     in   BYTE_ENABLE_WIDTH  per-byte write enable
//  write          in   1                  write request / beat valid
//  read           in   1                  read command
//  waitrequest    out  1                  slave not accepting this cycle
//  readdata       out  DATA_WIDTH         read beat data
//  readdatavalid  out  1                  readdata valid
//  protocol_err   out  1                  sticky: illegal master behaviour seen
// BEHAVIOUR
//  - Reset (async, rst_n=0): waitrequest=1, readdatavalid=0, readdata=0, protocol_err=0, FSM=IDLE,
//    latency pipe valids cleared; in-flight bursts/read data dropped. Memory array not reset.
//  - Word index = address[LSB +: MEM_WORDS_LOG2], LSB=log2(DATA_WIDTH/8); upper/low bits ignored.
//    Burst index increments by 1 per beat, wraps modulo 2**MEM_WORDS_LOG2.
//  - burstcount==0 treated as 1 and sets protocol_err.
//  - Stall: free-running counter mod WAIT_PERIOD; stall=1 when cnt==WAIT_PERIOD-1 (never if 0).
//    waitrequest = stall | (FSM==RD_ISSUE); cycle 0 after reset release counts as cnt=0.
//  - Accept = (read|write) & !waitrequest. Master holds signals while waitrequest=1.
//  - FSM IDLE: accepted write -> store beat 0 (byteenable-masked), latch index+1, rem=bc-1;
//    rem>0 -> WR_BURST else stay. Accepted read -> latch index, rem=bc -> RD_ISSUE.
//    read&write together: write wins, protocol_err=1.
//  - WR_BURST: each write&!waitrequest stores next beat, rem--; last beat -> IDLE.
//    read asserted in WR_BURST: ignored, protocol_err=1. Stall cycles pause burst, no data lost.
//  - RD_ISSUE: one word read per cycle (stall ignored), pushed into latency pipe, rem--;
//    last word -> IDLE. New commands blocked (waitrequest=1) throughout.
//  - Latency: word issued at cycle t -> readdatavalid=1 with its data at t+READ_LATENCY.
//    Data sampled from memory at issue; later writes do not alter issued words. Beats return
//    in order, back-to-back; a new command may be accepted while read data still draining.
//  - readdata holds last value when readdatavalid=0.
// TESTING
//  1 Reset: rst_n=0 mid read burst -> waitrequest=1, readdatavalid=0 next edge-independent; no beats after release.
//  2 Write addr 0x40 bc=4 data 1..4 be=all, WAIT_PERIOD=0; read 0x40 bc=4 accepted cyc T
//    -> readdatavalid at T+1+2..T+1+5, readdata 1,2,3,4.
//  3 Byteenable: write 0x0 data 0xFFFF_FFFF_FFFF_FFFF, then 0x0 data 0 be=0x0F; read -> 0xFFFF_FFFF_0000_0000.
//  4 Wrap: MEM_WORDS_LOG2=4, write 0x78 bc=2 data A,B -> read 0x78 = A, read 0x00 = B.
//  5 WAIT_PERIOD=3, write bc=6 -> waitrequest high every 3rd cycle, all 6 beats stored correctly.
//  6 read&write same cycle -> write stored, protocol_err=1 and stays 1 until reset.

Source files
------------

// File: rtl/avalon_mm_mem_slave.sv
// avalon_mm_mem_slave
//   Burst-capable Avalon-MM slave memory model. It has a fixed read latency,
//   optional periodic waitrequest stalls for back-pressure, and a sticky
//   protocol-error flag.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   IDLE     | ready for a new command (write beat 0 or read command)
//   WR_BURST | collecting the remaining beats of an accepted write burst
//   RD_ISSUE | reading one word per cycle into the latency pipe
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   address        byte address of first beat
//   burstcount     beats in burst (0 is treated as 1 and flagged)
//   writedata      write beat data
//   byteenable     per-byte write enable
//   write, read    master requests
//   waitrequest    slave not accepting this cycle
//   readdata       read beat data (holds while readdatavalid=0)
//   readdatavalid  readdata valid
//   protocol_err   sticky illegal-master-behaviour flag
module avalon_mm_mem_slave #(
  parameter int ADDR_WIDTH        = 32,
  parameter int DATA_WIDTH        = 64,
  parameter int BURST_COUNT_WIDTH = 8,
  parameter int BYTE_ENABLE_WIDTH = DATA_WIDTH / 8,
  parameter int MEM_WORDS_LOG2    = 10,
  parameter int READ_LATENCY      = 2,
  parameter int WAIT_PERIOD       = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [ADDR_WIDTH-1:0]        address,
  input  logic [BURST_COUNT_WIDTH-1:0] burstcount,
  input  logic [DATA_WIDTH-1:0]        writedata,
  input  logic [BYTE_ENABLE_WIDTH-1:0] byteenable,
  input  logic                         write,
  input  logic                         read,
  output logic                         waitrequest,
  output logic [DATA_WIDTH-1:0]        readdata,
  output logic                         readdatavalid,
  output logic                         protocol_err
);

  localparam int LSB   = $clog2(BYTE_ENABLE_WIDTH);
  localparam int DEPTH = 1 << MEM_WORDS_LOG2;

  typedef enum logic [1:0] {IDLE, WR_BURST, RD_ISSUE} state_t;
  state_t state, state_nxt;

  logic [MEM_WORDS_LOG2-1:0]    cmd_idx, wr_idx, rd_idx, mem_widx;
  logic [BURST_COUNT_WIDTH-1:0] rem, bc_eff;
  logic                         stall, accept, rem_last;
  logic                         wr_first, wr_next, rd_start, issue, perr_set, mem_we;
  logic                         unused_addr;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [READ_LATENCY-1:0] pipe_vld;
  logic [DATA_WIDTH-1:0]   pipe_dat [READ_LATENCY];

  // Bits outside the word index are deliberately ignored.
  assign unused_addr = ^address;
  assign cmd_idx     = address[LSB +: MEM_WORDS_LOG2];
  assign bc_eff      = (burstcount == '0) ? BURST_COUNT_WIDTH'(1) : burstcount;
  assign rem_last    = (rem == BURST_COUNT_WIDTH'(1));

  // Free-running stall counter; the first cycle after reset release is count 0.
  generate
    if (WAIT_PERIOD >= 2) begin : g_stall
      localparam int CW = $clog2(WAIT_PERIOD);
      logic [CW-1:0] cnt;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         cnt <= '0;
        else if (cnt == CW'(WAIT_PERIOD-1)) cnt <= '0;
        else                                cnt <= cnt + CW'(1);
      end
      assign stall = (cnt == CW'(WAIT_PERIOD-1));
    end else begin : g_no_stall
      assign stall = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (wr_first)      state_nxt = (bc_eff > BURST_COUNT_WIDTH'(1)) ? WR_BURST : IDLE;
        else if (rd_start) state_nxt = RD_ISSUE;
      end
      WR_BURST: if (wr_next && rem_last) state_nxt = IDLE;
      RD_ISSUE: if (rem_last)            state_nxt = IDLE;
      default:                           state_nxt = IDLE;
    endcase
  end

  // waitrequest is also held high while reset is asserted.
  always_comb begin
    waitrequest = !rst_n | stall | (state == RD_ISSUE);
    accept      = (read | write) & !waitrequest;
    wr_first    = 1'b0;
    wr_next     = 1'b0;
    rd_start    = 1'b0;
    issue       = 1'b0;
    perr_set    = 1'b0;
    case (state)
      IDLE: begin
        wr_first = accept & write;
        rd_start = accept & read & !write;
        perr_set = accept & ((read & write) | (burstcount == '0));
      end
      WR_BURST: begin
        wr_next  = write & !waitrequest;
        perr_set = read;
      end
      RD_ISSUE: issue = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx       <= '0;
      rd_idx       <= '0;
      rem          <= '0;
      protocol_err <= 1'b0;
    end else begin
      if (perr_set) protocol_err <= 1'b1;
      if (wr_first) begin
        wr_idx <= cmd_idx + MEM_WORDS_LOG2'(1);
        rem    <= bc_eff - BURST_COUNT_WIDTH'(1);
      end else if (wr_next) begin
        wr_idx <= wr_idx + MEM_WORDS_LOG2'(1);
        rem    <= rem - BURST_COUNT_WIDTH'(1);
      end else if (rd_start) begin
        rd_idx <= cmd_idx;
        rem    <= bc_eff;
      end else if (issue) begin
        rd_idx <= rd_idx + MEM_WORDS_LOG2'(1);
        rem    <= rem - BURST_COUNT_WIDTH'(1);
      end
    end
  end

  assign mem_we   = wr_first | wr_next;
  assign mem_widx = wr_first ? cmd_idx : wr_idx;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < BYTE_ENABLE_WIDTH; b++) begin
        if (byteenable[b]) mem[mem_widx][b*8 +: 8] <= writedata[b*8 +: 8];
      end
    end
  end

  // Data is captured at issue so later writes cannot disturb words in flight.
  // Data stages only load on a valid beat, which makes readdata hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld <= '0;
      for (int i = 0; i < READ_LATENCY; i++) pipe_dat[i] <= '0;
    end else begin
      pipe_vld[0] <= issue;
      if (issue) pipe_dat[0] <= mem[rd_idx];
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        if (pipe_vld[i-1]) pipe_dat[i] <= pipe_dat[i-1];
      end
    end
  end

  assign readdatavalid = pipe_vld[READ_LATENCY-1];
  assign readdata      = pipe_dat[READ_LATENCY-1];

endmodule

// File: tb/tb_avalon_mm_mem_slave.sv
module tb_avalon_mm_mem_slave;
  localparam int AW = 32, DW = 64, BCW = 8, BEW = 8;
  localparam int MWL = 4, RL = 2, WP = 3;
  localparam int D = 1 << MWL;
  localparam int LSB = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [AW-1:0]  address = '0;
  logic [BCW-1:0] burstcount = 8'd1;
  logic [DW-1:0]  writedata = '0;
  logic [BEW-1:0] byteenable = '1;
  logic           write = 1'b0;
  logic           read = 1'b0;
  logic           waitrequest, readdatavalid, protocol_err;
  logic [DW-1:0]  readdata;

  always #5 clk = ~clk;

  avalon_mm_mem_slave #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_COUNT_WIDTH(BCW), .BYTE_ENABLE_WIDTH(BEW),
    .MEM_WORDS_LOG2(MWL), .READ_LATENCY(RL), .WAIT_PERIOD(WP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .address(address), .burstcount(burstcount),
    .writedata(writedata), .byteenable(byteenable), .write(write), .read(read),
    .waitrequest(waitrequest), .readdata(readdata), .readdatavalid(readdatavalid),
    .protocol_err(protocol_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Cycle index since reset release (cycle 0 is the one right after release).
  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // ---------------- behavioural model ----------------
  typedef struct { int c; logic [63:0] d; } beat_t;
  logic [63:0] mem_m [D];
  beat_t       exp_q[$];
  int          got_c[$];
  logic [63:0] got_d[$];
  int          busy_lo = 1, busy_hi = 0;
  int          perr_from = -1;
  logic [63:0] last_rd = '0;
  logic [63:0] wd [32];
  logic [7:0]  wbe [32];

  function automatic bit model_wait(int k);
    return (WP >= 2 && (k % WP) == WP - 1) || (k >= busy_lo && k <= busy_hi);
  endfunction

  function automatic int widx(logic [31:0] a);
    return int'((a >> LSB) % D);
  endfunction

  function automatic logic [63:0] got_dat(int j);
    return (j < got_d.size()) ? got_d[j] : 64'hx;
  endfunction

  function automatic int got_cyc(int j);
    return (j < got_c.size()) ? got_c[j] : -1;
  endfunction

  task automatic perr_event(int t);
    if (perr_from < 0) perr_from = t + 1;
  endtask

  task automatic check1(string name, logic act, logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check64(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_int(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      check1("rst_waitrequest", waitrequest, 1'b1);
      check1("rst_readdatavalid", readdatavalid, 1'b0);
    end else begin
      check1("waitrequest", waitrequest, model_wait(cyc));
      if (exp_q.size() > 0 && exp_q[0].c == cyc) begin
        check1("readdatavalid", readdatavalid, 1'b1);
        check64("readdata", readdata, exp_q[0].d);
        last_rd = exp_q[0].d;
        void'(exp_q.pop_front());
      end else begin
        check1("readdatavalid_idle", readdatavalid, 1'b0);
        check64("readdata_hold", readdata, last_rd);
      end
      if (readdatavalid) begin
        got_c.push_back(cyc);
        got_d.push_back(readdata);
      end
      check1("protocol_err", protocol_err, perr_from >= 0 && cyc >= perr_from);
    end
  end

  // ---------------- driver ----------------
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(input bit rd_in_burst, output int t);
    int guard;
    guard = 0;
    while (model_wait(cyc)) begin
      if (rd_in_burst) perr_event(cyc);
      guard++;
      if (guard > 64) begin
        n_checks++;
        n_fail++;
        $display("FAIL accept_timeout: stalled %0d cycles, required acceptance", guard);
        break;
      end
      next_cyc();
    end
    if (rd_in_burst) perr_event(cyc);
    t = cyc;
  endtask

  task automatic do_write(input logic [31:0] addr, input int bc, input int rd_beat, input bit gaps);
    int nb, base, t, g;
    nb   = (bc == 0) ? 1 : bc;
    base = widx(addr);
    for (int b = 0; b < nb; b++) begin
      if (gaps) begin
        g = $urandom_range(0, 2);
        repeat (g) next_cyc();
      end
      address    = addr;
      burstcount = BCW'(bc);
      writedata  = wd[b];
      byteenable = wbe[b];
      write      = 1'b1;
      read       = (b == rd_beat);
      wait_accept(b > 0 && b == rd_beat, t);
      for (int i = 0; i < 8; i++)
        if (wbe[b][i]) mem_m[(base + b) % D][i*8 +: 8] = wd[b][i*8 +: 8];
      if (b == 0 && (bc == 0 || rd_beat == 0)) perr_event(t);
      next_cyc();
      write = 1'b0;
      read  = 1'b0;
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input int bc, output int t);
    int n;
    beat_t e;
    address    = addr;
    burstcount = BCW'(bc);
    read       = 1'b1;
    write      = 1'b0;
    wait_accept(1'b0, t);
    n = (bc == 0) ? 1 : bc;
    if (bc == 0) perr_event(t);
    busy_lo = t + 1;
    busy_hi = t + n;
    for (int j = 0; j < n; j++) begin
      e.c = t + 1 + j + RL;
      e.d = mem_m[(widx(addr) + j) % D];
      exp_q.push_back(e);
    end
    next_cyc();
    read = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    write = 1'b0;
    read  = 1'b0;
    exp_q.delete();
    busy_lo = 1;
    busy_hi = 0;
    perr_from = -1;
    last_rd = '0;
    #1;
    check1("rst_async_waitrequest", waitrequest, 1'b1);
    check1("rst_async_rdv", readdatavalid, 1'b0);
    check64("rst_async_readdata", readdata, 64'h0);
    check1("rst_async_perr", protocol_err, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    next_cyc();
  endtask

  task automatic clear_got();
    got_c.delete();
    got_d.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int t, bc, n;
    logic [31:0] a;

    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    next_cyc();
    check1("post_reset_perr", protocol_err, 1'b0);

    // Fill the whole memory so every later read has known contents.
    for (int j = 0; j < D; j++) begin
      wd[j]  = {$urandom, $urandom};
      wbe[j] = 8'hFF;
    end
    do_write(32'h0, D, -1, 1'b1);
    do_read(32'h0, D, t);
    repeat (D + 6) next_cyc();

    // Reset in the middle of a read burst; no beats may follow.
    do_read(32'h0, 8, t);
    repeat (3) next_cyc();
    do_reset();
    repeat (12) next_cyc();

    // Burst write then read with fixed latency.
    for (int j = 0; j < 4; j++) begin
      wd[j]  = 64'(j + 1);
      wbe[j] = 8'hFF;
    end
    do_write(32'h40, 4, -1, 1'b0);
    clear_got();
    do_read(32'h40, 4, t);
    repeat (10) next_cyc();
    check_int("t2_beats", got_c.size(), 4);
    for (int j = 0; j < 4; j++) begin
      check_int("t2_cycle", got_cyc(j), t + 1 + 2 + j);
      check64("t2_data", got_dat(j), 64'(j + 1));
    end

    // Byteenable merge.
    wd[0] = 64'hFFFF_FFFF_FFFF_FFFF; wbe[0] = 8'hFF;
    do_write(32'h0, 1, -1, 1'b0);
    wd[0] = 64'h0; wbe[0] = 8'h0F;
    do_write(32'h0, 1, -1, 1'b0);
    check64("t3_model", mem_m[0], 64'hFFFF_FFFF_0000_0000);
    clear_got();
    do_read(32'h0, 1, t);
    repeat (6) next_cyc();
    check64("t3_data", got_dat(0), 64'hFFFF_FFFF_0000_0000);

    // Wrap at the top of memory.
    wd[0] = 64'hA5A5_0000_1111_2222; wbe[0] = 8'hFF;
    wd[1] = 64'h5A5A_FFFF_3333_4444; wbe[1] = 8'hFF;
    do_write(32'h78, 2, -1, 1'b0);
    clear_got();
    do_read(32'h78, 1, t);
    do_read(32'h00, 1, t);
    do_read(32'h78, 2, t);
    repeat (8) next_cyc();
    check64("t4_word15", got_dat(0), 64'hA5A5_0000_1111_2222);
    check64("t4_word0", got_dat(1), 64'h5A5A_FFFF_3333_4444);
    check64("t4_wrap_rd0", got_dat(2), 64'hA5A5_0000_1111_2222);
    check64("t4_wrap_rd1", got_dat(3), 64'h5A5A_FFFF_3333_4444);

    // Six-beat write through periodic stalls.
    for (int j = 0; j < 6; j++) begin
      wd[j]  = 64'h1000 + 64'(j);
      wbe[j] = 8'hFF;
    end
    do_write(32'h10, 6, -1, 1'b0);
    clear_got();
    do_read(32'h10, 6, t);
    repeat (10) next_cyc();
    for (int j = 0; j < 6; j++) check64("t5_data", got_dat(j), 64'h1000 + 64'(j));

    // Randomized traffic, including reads that wrap and writes during drain.
    for (int it = 0; it < 80; it++) begin
      a  = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        bc = $urandom_range(1, 6);
        for (int j = 0; j < bc; j++) begin
          wd[j]  = {$urandom, $urandom};
          wbe[j] = 8'($urandom);
        end
        do_write(a, bc, -1, 1'b1);
      end else begin
        bc = $urandom_range(1, 20);
        do_read(a, bc, t);
      end
      n = $urandom_range(0, 2);
      repeat (n) next_cyc();
    end
    repeat (30) next_cyc();

    // burstcount 0 behaves as a single beat and flags an error.
    wd[0] = 64'hBC00_0000_0000_00BC; wbe[0] = 8'hFF;
    do_write(32'h20, 0, -1, 1'b0);
    check1("bc0_perr", protocol_err, 1'b1);
    clear_got();
    do_read(32'h20, 1, t);
    repeat (6) next_cyc();
    check64("bc0_data", got_dat(0), 64'hBC00_0000_0000_00BC);
    do_reset();

    // Read asserted inside a write burst is ignored but flagged.
    for (int j = 0; j < 3; j++) begin
      wd[j]  = 64'h3000 + 64'(j);
      wbe[j] = 8'hFF;
    end
    do_write(32'h30, 3, 1, 1'b0);
    check1("rd_in_burst_perr", protocol_err, 1'b1);
    clear_got();
    do_read(32'h30, 3, t);
    repeat (8) next_cyc();
    for (int j = 0; j < 3; j++) check64("rd_in_burst_data", got_dat(j), 64'h3000 + 64'(j));
    do_reset();

    // read and write together: write wins, error is sticky.
    wd[0] = 64'hDEAD_BEEF_0123_4567; wbe[0] = 8'hFF;
    do_write(32'h50, 1, 0, 1'b0);
    check1("rw_perr", protocol_err, 1'b1);
    clear_got();
    do_read(32'h50, 1, t);
    repeat (6) next_cyc();
    check64("rw_data", got_dat(0), 64'hDEAD_BEEF_0123_4567);
    for (int it = 0; it < 5; it++) begin
      do_read($urandom, $urandom_range(1, 4), t);
    end
    repeat (12) next_cyc();
    check1("rw_perr_sticky", protocol_err, 1'b1);
    do_reset();
    repeat (4) next_cyc();

    check_int("drain_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
